// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared AXI4-Lite types: address/data/strobe/response widths, response codes
// and the channel FSM state encodings used by the register slave.
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// -----------------------------------------------------------------------------
// axi_lite_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives addresses, write data, valids and response readies
//   slave  modport : drives address/data readies, responses and read data
// -----------------------------------------------------------------------------
interface axi_lite_if;
    import axi_lite_pkg::*;

    addr_t awaddr;
    logic  awvalid;
    logic  awready;
    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;
    resp_t bresp;
    logic  bvalid;
    logic  bready;
    addr_t araddr;
    logic  arvalid;
    logic  arready;
    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_regbank.sv
// -----------------------------------------------------------------------------
// axi_lite_regbank
// NUM_REGS x 32-bit register storage with one byte-strobed write port, a
// combinational read mux, a flat export of all registers and a one-cycle
// commit pulse per register.
//   aclk, areset   : clock, asynchronous active-high reset
//   i_wr_en        : commit i_wr_data into register i_wr_idx under i_wr_strb
//   i_rd_idx       : read mux select, o_rd_data is the current register value
//   o_reg_out      : register i at bits [32*i+31:32*i]
//   o_wr_pulse     : bit i high for the cycle after register i is committed
// -----------------------------------------------------------------------------
module axi_lite_regbank
    import axi_lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_wr_idx,
    input  data_t                    i_wr_data,
    input  strb_t                    i_wr_strb,
    input  logic [IDX_W-1:0]         i_rd_idx,
    output data_t                    o_rd_data,
    output logic [NUM_REGS*32-1:0]   o_reg_out,
    output logic [NUM_REGS-1:0]      o_wr_pulse
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic  w_sel;
            data_t r_reg;
            logic  r_pulse;

            assign w_sel = i_wr_en && (i_wr_idx == IDX_W'(gi));

            always_ff @(posedge aclk or posedge areset) begin
                if (areset) begin
                    r_reg   <= '0;
                    r_pulse <= 1'b0;
                end else begin
                    // The pulse fires on every commit, even with no strobe bits set.
                    r_pulse <= w_sel;
                    if (w_sel) begin
                        for (int b = 0; b < 4; b++) begin
                            if (i_wr_strb[b]) begin
                                r_reg[8*b +: 8] <= i_wr_data[8*b +: 8];
                            end
                        end
                    end
                end
            end

            assign o_reg_out[32*gi +: 32] = r_reg;
            assign o_wr_pulse[gi]         = r_pulse;
        end
    endgenerate

    // The caller only uses this value for in-range indices.
    assign o_rd_data = o_reg_out[{i_rd_idx, 5'b0} +: 32];

endmodule

// File: rtl/axi_lite_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_slave
// AXI4-Lite register slave: NUM_REGS 32-bit read/write registers starting at
// byte address BASE_ADDR. Write and read channels are independent FSMs; every
// handshake ready and every response output is registered.
//   aclk, areset : clock, asynchronous active-high reset
//   s_axi_lite   : AXI4-Lite slave port (AW/W/B/AR/R)
//   reg_out      : flat register contents, reg i at bits [32*i+31:32*i]
//   wr_pulse     : one-cycle pulse after register i is written
// -----------------------------------------------------------------------------
module axi_lite_slave
    import axi_lite_pkg::*;
#(
    parameter int    NUM_REGS  = 8,
    parameter addr_t BASE_ADDR = 32'h0
) (
    input  logic                    aclk,
    input  logic                    areset,
    axi_lite_if.slave               s_axi_lite,
    output logic [NUM_REGS*32-1:0]  reg_out,
    output logic [NUM_REGS-1:0]     wr_pulse
);

    localparam int    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam addr_t NUM_REGS_A = addr_t'(NUM_REGS);

    // Byte offset from the window base; addr[1:0] drop out in the shift.
    function automatic logic in_window(addr_t a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < NUM_REGS_A);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(addr_t a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // ---------------- write channel ----------------
    wr_state_t r_wstate, w_wstate_next;
    logic      r_awready, w_awready_next;
    logic      r_wready, w_wready_next;
    logic      r_bvalid, w_bvalid_next;
    resp_t     r_bresp, w_bresp_next;
    addr_t     r_awaddr, w_awaddr_next;
    data_t     r_wdata, w_wdata_next;
    strb_t     r_wstrb, w_wstrb_next;

    logic      w_aw_hs, w_w_hs, w_commit, w_wr_hit;
    addr_t     w_cm_addr;
    data_t     w_cm_data;
    strb_t     w_cm_strb;

    assign w_aw_hs  = s_axi_lite.awvalid && r_awready;
    assign w_w_hs   = s_axi_lite.wvalid && r_wready;
    assign w_wr_hit = in_window(w_cm_addr);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_wstate  <= w_wstate_next;
            r_awready <= w_awready_next;
            r_wready  <= w_wready_next;
            r_bvalid  <= w_bvalid_next;
            r_bresp   <= w_bresp_next;
            r_awaddr  <= w_awaddr_next;
            r_wdata   <= w_wdata_next;
            r_wstrb   <= w_wstrb_next;
        end
    end

    always_comb begin
        w_wstate_next  = r_wstate;
        w_awready_next = r_awready;
        w_wready_next  = r_wready;
        w_bvalid_next  = r_bvalid;
        w_bresp_next   = r_bresp;
        w_awaddr_next  = r_awaddr;
        w_wdata_next   = r_wdata;
        w_wstrb_next   = r_wstrb;
        w_commit       = 1'b0;
        w_cm_addr      = s_axi_lite.awaddr;
        w_cm_data      = s_axi_lite.wdata;
        w_cm_strb      = s_axi_lite.wstrb;

        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit = 1'b1;
                end else if (w_aw_hs) begin
                    w_awaddr_next  = s_axi_lite.awaddr;
                    w_awready_next = 1'b0;
                    w_wready_next  = 1'b1;
                    w_wstate_next  = W_HAVE_ADDR;
                end else if (w_w_hs) begin
                    w_wdata_next   = s_axi_lite.wdata;
                    w_wstrb_next   = s_axi_lite.wstrb;
                    w_awready_next = 1'b1;
                    w_wready_next  = 1'b0;
                    w_wstate_next  = W_HAVE_DATA;
                end else begin
                    // Also raises the readies on the first edge after reset.
                    w_awready_next = 1'b1;
                    w_wready_next  = 1'b1;
                end
            end
            W_HAVE_ADDR: begin
                w_cm_addr = r_awaddr;
                w_commit  = w_w_hs;
            end
            W_HAVE_DATA: begin
                w_cm_data = r_wdata;
                w_cm_strb = r_wstrb;
                w_commit  = w_aw_hs;
            end
            W_RESP: begin
                if (s_axi_lite.bready) begin
                    w_bvalid_next  = 1'b0;
                    w_awready_next = 1'b1;
                    w_wready_next  = 1'b1;
                    w_wstate_next  = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase

        if (w_commit) begin
            w_awready_next = 1'b0;
            w_wready_next  = 1'b0;
            w_bvalid_next  = 1'b1;
            w_bresp_next   = w_wr_hit ? RESP_OKAY : RESP_SLVERR;
            w_wstate_next  = W_RESP;
        end
    end

    // ---------------- read channel ----------------
    rd_state_t r_rstate, w_rstate_next;
    logic      r_arready, w_arready_next;
    logic      r_rvalid, w_rvalid_next;
    resp_t     r_rresp, w_rresp_next;
    data_t     r_rdata, w_rdata_next;
    data_t     w_rd_data;
    logic      w_rd_hit;

    assign w_rd_hit = in_window(s_axi_lite.araddr);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_rstate  <= w_rstate_next;
            r_arready <= w_arready_next;
            r_rvalid  <= w_rvalid_next;
            r_rresp   <= w_rresp_next;
            r_rdata   <= w_rdata_next;
        end
    end

    always_comb begin
        w_rstate_next  = r_rstate;
        w_arready_next = r_arready;
        w_rvalid_next  = r_rvalid;
        w_rresp_next   = r_rresp;
        w_rdata_next   = r_rdata;

        case (r_rstate)
            R_IDLE: begin
                if (s_axi_lite.arvalid && r_arready) begin
                    // Sampled before any same-edge commit lands: pre-write value.
                    w_rdata_next   = w_rd_hit ? w_rd_data : '0;
                    w_rresp_next   = w_rd_hit ? RESP_OKAY : RESP_SLVERR;
                    w_rvalid_next  = 1'b1;
                    w_arready_next = 1'b0;
                    w_rstate_next  = R_DATA;
                end else begin
                    w_arready_next = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi_lite.rready) begin
                    w_rvalid_next  = 1'b0;
                    w_arready_next = 1'b1;
                    w_rstate_next  = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // ---------------- storage ----------------
    axi_lite_regbank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regbank (
        .aclk       (aclk),
        .areset     (areset),
        .i_wr_en    (w_commit && w_wr_hit),
        .i_wr_idx   (to_idx(w_cm_addr)),
        .i_wr_data  (w_cm_data),
        .i_wr_strb  (w_cm_strb),
        .i_rd_idx   (to_idx(s_axi_lite.araddr)),
        .o_rd_data  (w_rd_data),
        .o_reg_out  (reg_out),
        .o_wr_pulse (wr_pulse)
    );

    assign s_axi_lite.awready = r_awready;
    assign s_axi_lite.wready  = r_wready;
    assign s_axi_lite.bvalid  = r_bvalid;
    assign s_axi_lite.bresp   = r_bresp;
    assign s_axi_lite.arready = r_arready;
    assign s_axi_lite.rvalid  = r_rvalid;
    assign s_axi_lite.rresp   = r_rresp;
    assign s_axi_lite.rdata   = r_rdata;

endmodule

// File: tb/tb_axi_lite_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_slave
// Directed bench for axi_lite_slave (NUM_REGS=8, BASE_ADDR=0): a table of
// single read/write transactions with hand-computed results, followed by
// hand-written sequences for split write order, back-pressure, simultaneous
// read/write and reset in the middle of a write.
// -----------------------------------------------------------------------------
module tb_axi_lite_slave;
    import axi_lite_pkg::*;

    localparam int NR = 8;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0]    wr_pulse;

    axi_lite_if axi ();

    axi_lite_slave #(
        .NUM_REGS  (NR),
        .BASE_ADDR (32'h0)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_axi_lite (axi.slave),
        .reg_out    (reg_out),
        .wr_pulse   (wr_pulse)
    );

    always #5 aclk = ~aclk;

    int n_cmp  = 0;
    int n_fail = 0;

    data_t model [NR];

    typedef struct {
        bit          is_wr;
        addr_t       addr;
        data_t       data;
        strb_t       strb;
        resp_t       resp;
        data_t       exp;     // read data, or new register value for a write
        logic [7:0]  pulse;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string nm);
        logic [NR*32-1:0] e;
        for (int i = 0; i < NR; i++) e[32*i +: 32] = model[i];
        n_cmp++;
        if (reg_out !== e) begin
            n_fail++;
            $display("FAIL %s: reg_out got %h, expected %h", nm, reg_out, e);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Write with bready=1; returns response, wr_pulse seen with bvalid, and
    // edges from the start to bvalid.
    task automatic do_write(input addr_t a, input data_t d, input strb_t s,
                            output resp_t resp, output logic [7:0] pulse, output int lat);
        logic aw_go, w_go;
        axi.awaddr = a; axi.awvalid = 1'b1;
        axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
        axi.bready = 1'b1;
        resp = 2'b11; pulse = '0; lat = -1;
        for (int c = 1; c <= 20; c++) begin
            aw_go = axi.awvalid && axi.awready;
            w_go  = axi.wvalid && axi.wready;
            tick();
            if (aw_go) axi.awvalid = 1'b0;
            if (w_go)  axi.wvalid  = 1'b0;
            if (axi.bvalid) begin
                resp = axi.bresp; pulse = wr_pulse; lat = c;
                break;
            end
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        if (lat < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL write_timeout: addr %h no bvalid within 20 cycles", a);
        end else begin
            tick();
        end
        $display("WR addr=%h data=%h strb=%h -> bresp=%b pulse=%h lat=%0d", a, d, s, resp, pulse, lat);
    endtask

    task automatic do_read(input addr_t a, output data_t d, output resp_t resp, output int lat);
        logic ar_go;
        axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b1;
        d = 'x; resp = 2'b11; lat = -1;
        for (int c = 1; c <= 20; c++) begin
            ar_go = axi.arvalid && axi.arready;
            tick();
            if (ar_go) axi.arvalid = 1'b0;
            if (axi.rvalid) begin
                d = axi.rdata; resp = axi.rresp; lat = c;
                break;
            end
        end
        axi.arvalid = 1'b0;
        if (lat < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL read_timeout: addr %h no rvalid within 20 cycles", a);
        end else begin
            tick();
        end
        $display("RD addr=%h -> rdata=%h rresp=%b lat=%0d", a, d, resp, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t      r;
        data_t      d;
        logic [7:0] p;
        int         lat;

        axi.awaddr = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
        axi.bready = 1'b0;
        axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        //          wr  addr          data          strb   resp         exp           pulse
        vecs[0]  = '{1, 32'h0000_0004, 32'hdeadbeef, 4'hF, RESP_OKAY,   32'hdeadbeef, 8'h02};
        vecs[1]  = '{0, 32'h0000_0004, 32'h0,        4'h0, RESP_OKAY,   32'hdeadbeef, 8'h00};
        vecs[2]  = '{1, 32'h0000_0008, 32'h11223344, 4'hF, RESP_OKAY,   32'h11223344, 8'h04};
        vecs[3]  = '{1, 32'h0000_001C, 32'hcafef00d, 4'hF, RESP_OKAY,   32'hcafef00d, 8'h80};
        vecs[4]  = '{1, 32'h0000_001F, 32'h12345678, 4'hC, RESP_OKAY,   32'h1234f00d, 8'h80};
        vecs[5]  = '{0, 32'h0000_001E, 32'h0,        4'h0, RESP_OKAY,   32'h1234f00d, 8'h00};
        vecs[6]  = '{1, 32'h0000_0020, 32'hffffffff, 4'hF, RESP_SLVERR, 32'h0,        8'h00};
        vecs[7]  = '{0, 32'h0000_0024, 32'h0,        4'h0, RESP_SLVERR, 32'h0,        8'h00};
        vecs[8]  = '{1, 32'h0000_0000, 32'hffffffff, 4'h0, RESP_OKAY,   32'h0,        8'h01};
        vecs[9]  = '{0, 32'h0000_0000, 32'h0,        4'h0, RESP_OKAY,   32'h0,        8'h00};
        vecs[10] = '{0, 32'hFFFF_FFFC, 32'h0,        4'h0, RESP_SLVERR, 32'h0,        8'h00};
        vecs[11] = '{0, 32'h0000_001C, 32'h0,        4'h0, RESP_OKAY,   32'h1234f00d, 8'h00};

        // ---- reset: three cycles held, everything quiet ----
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset_ready_valid", 32'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 32'h0);
        end
        areset = 1'b0;
        chk("release_ready_still_low", 32'({axi.awready, axi.wready, axi.arready}), 32'h0);
        tick();
        chk("ready_after_release", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
        chk("wr_pulse_after_reset", 32'(wr_pulse), 32'h0);
        chk_regs("reg_out_after_reset");

        // ---- table of single transactions ----
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, p, lat);
                chk($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
                chk($sformatf("v%0d_wr_pulse", i), 32'(p), 32'(vecs[i].pulse));
                chk($sformatf("v%0d_b_latency", i), 32'(lat), 32'd1);
                if (vecs[i].resp == RESP_OKAY) model[vecs[i].addr[4:2]] = vecs[i].exp;
                chk_regs($sformatf("v%0d_reg_out", i));
                chk($sformatf("v%0d_pulse_gone", i), 32'(wr_pulse), 32'h0);
            end else begin
                do_read(vecs[i].addr, d, r, lat);
                chk($sformatf("v%0d_rdata", i), d, vecs[i].exp);
                chk($sformatf("v%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
                chk($sformatf("v%0d_r_latency", i), 32'(lat), 32'd1);
            end
            chk($sformatf("v%0d_idle_ready", i), 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
        end

        // ---- split order: W three cycles before AW, partial strobe, B held ----
        axi.bready = 1'b0;
        axi.wdata = 32'hAABBCCDD; axi.wstrb = 4'b0101; axi.wvalid = 1'b1;
        tick();
        axi.wvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk("split_wready_low", 32'(axi.wready), 32'h0);
            chk("split_no_bvalid", 32'(axi.bvalid), 32'h0);
            tick();
        end
        axi.awaddr = 32'h8; axi.awvalid = 1'b1;
        chk("split_awready_high", 32'(axi.awready), 32'h1);
        tick();
        axi.awvalid = 1'b0;
        chk("split_bvalid", 32'(axi.bvalid), 32'h1);
        chk("split_bresp", 32'(axi.bresp), 32'(RESP_OKAY));
        chk("split_wr_pulse", 32'(wr_pulse), 32'h04);
        model[2] = 32'h11BB33DD;
        chk_regs("split_reg_out");
        $display("WR split addr=00000008 data=aabbccdd strb=5 -> bresp=%b", axi.bresp);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_b_bvalid_held", 32'(axi.bvalid), 32'h1);
            chk("bp_b_bresp_held", 32'(axi.bresp), 32'(RESP_OKAY));
            chk("bp_b_readies_low", 32'({axi.awready, axi.wready}), 32'h0);
        end
        axi.bready = 1'b1;
        tick();
        chk("bp_b_released", 32'({axi.bvalid, axi.awready, axi.wready}), 32'h3);

        // ---- read back-pressure ----
        axi.rready = 1'b0;
        axi.araddr = 32'h8; axi.arvalid = 1'b1;
        tick();
        axi.arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_r_rvalid_held", 32'(axi.rvalid), 32'h1);
            chk("bp_r_rdata_held", axi.rdata, 32'h11BB33DD);
            chk("bp_r_arready_low", 32'(axi.arready), 32'h0);
            tick();
        end
        $display("RD held addr=00000008 -> rdata=%h rresp=%b", axi.rdata, axi.rresp);
        axi.rready = 1'b1;
        tick();
        chk("bp_r_released", 32'({axi.rvalid, axi.arready}), 32'h1);

        // ---- simultaneous read and write of reg4: read sees old value ----
        axi.awaddr = 32'h10; axi.awvalid = 1'b1;
        axi.wdata = 32'h55; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        axi.araddr = 32'h10; axi.arvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        chk("rw_same_rdata_old", axi.rdata, 32'h0);
        chk("rw_same_valids", 32'({axi.bvalid, axi.rvalid}), 32'h3);
        model[4] = 32'h55;
        chk_regs("rw_same_reg_out");
        $display("RW same addr=00000010 -> rdata=%h bresp=%b", axi.rdata, axi.bresp);
        tick();
        do_read(32'h10, d, r, lat);
        chk("rw_same_readback", d, 32'h55);

        // ---- reset in the middle of a write ----
        axi.awaddr = 32'hC; axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        chk("midrst_have_addr", 32'({axi.awready, axi.wready}), 32'h1);
        areset = 1'b1;
        #2;
        chk("midrst_outputs_low", 32'({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid}), 32'h0);
        areset = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        tick();
        chk("midrst_ready_back", 32'({axi.awready, axi.wready, axi.arready}), 32'h7);
        tick();
        chk("midrst_no_bvalid", 32'(axi.bvalid), 32'h0);
        chk("midrst_no_pulse", 32'(wr_pulse), 32'h0);
        chk_regs("midrst_reg_out");
        $display("RST mid-write addr=0000000c discarded");
        do_write(32'hC, 32'h77777777, 4'hF, r, p, lat);
        chk("midrst_next_bresp", 32'(r), 32'(RESP_OKAY));
        chk("midrst_next_pulse", 32'(p), 32'h08);
        chk("midrst_next_latency", 32'(lat), 32'd1);
        do_read(32'hC, d, r, lat);
        chk("midrst_next_readback", d, 32'h77777777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
